// File: rtl/mem_port_arb.sv
// Single-port memory arbiter between instruction fetch and data access, with fetch flush (kill) handling.
// Optional fetch starvation guard enabled by defining MEM_PORT_ARB_STARVE_GUARD_EN.
module mem_port_arb #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    input  logic                i_branch_met,
    input  logic                i_data_req,
    input  logic                i_data_we,
    input  logic [ADDR_W-1:0]   i_data_addr,
    input  logic [DATA_W-1:0]   i_data_wdata,
    input  logic [DATA_W/8-1:0] i_data_be,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_be,
    input  logic                i_mem_ready,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic                o_if_valid,
    output logic [DATA_W-1:0]   o_if_rdata,
    output logic                o_data_valid,
    output logic [DATA_W-1:0]   o_data_rdata,
    output logic                o_stall_r
);

    typedef enum logic [1:0] {
        IDLE,
        IF_ACC,
        DATA_ACC
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   grant_if;
    logic   grant_data;
    logic   complete;
    logic   force_if;
    logic   kill;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("mem_port_arb: STARVE_LIMIT must be in 1..15");
    end

`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt;

    // Counts back-to-back data grants that left a fetch waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= '0;
        end else if (grant_data) begin
            if (!i_if_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != 4'hF) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    assign force_if = i_if_req && (starve_cnt >= 4'(STARVE_LIMIT));
`else
    assign force_if = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_if   = 1'b0;
        grant_data = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (i_data_req && !force_if) begin
                    grant_data = 1'b1;
                    state_nxt  = DATA_ACC;
                end else if (i_if_req) begin
                    grant_if  = 1'b1;
                    state_nxt = IF_ACC;
                end
            end
            IF_ACC, DATA_ACC: begin
                if (i_mem_ready) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus fields are loaded at grant and held untouched until the completion strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_mem_req    <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_wdata  <= '0;
            o_mem_be     <= '0;
            o_if_valid   <= 1'b0;
            o_if_rdata   <= '0;
            o_data_valid <= 1'b0;
            o_data_rdata <= '0;
            o_stall_r    <= 1'b0;
            kill         <= 1'b0;
        end else begin
            o_if_valid   <= 1'b0;
            o_data_valid <= 1'b0;
            o_stall_r    <= i_data_req && !((state == DATA_ACC) && i_mem_ready);
            if (grant_if) begin
                o_mem_req   <= 1'b1;
                o_mem_we    <= 1'b0;
                o_mem_addr  <= i_if_addr;
                o_mem_wdata <= '0;
                o_mem_be    <= '1;
            end else if (grant_data) begin
                o_mem_req   <= 1'b1;
                o_mem_we    <= i_data_we;
                o_mem_addr  <= i_data_addr;
                o_mem_wdata <= i_data_wdata;
                o_mem_be    <= i_data_be;
            end
            // A flushed fetch still finishes on the bus; only its valid pulse is dropped.
            if (complete) begin
                o_mem_req <= 1'b0;
                if (state == IF_ACC) begin
                    o_if_rdata <= i_mem_rdata;
                    o_if_valid <= !(kill || i_branch_met);
                    kill       <= 1'b0;
                end else begin
                    o_data_rdata <= i_mem_rdata;
                    o_data_valid <= 1'b1;
                end
            end else if ((state == IF_ACC) && i_branch_met) begin
                kill <= 1'b1;
            end
        end
    end

endmodule
